// File: rtl/spi_master_param_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_master_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_END   = 3'd4
  } state_e;

  // Bit positions inside the latched {cpol, cpha} mode word.
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned MODE_CPHA = 0;
  localparam int unsigned MODE_CPOL = 1;

  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_param_clk_gen.sv
// Half-period divider and spi_clk toggle counter; strobes only fire while shifting.
module spi_master_param_clk_gen
  import spi_master_param_pkg::*;
#(
  parameter int unsigned HALF    = 2,
  parameter int unsigned TOGGLES = 16,
  localparam int unsigned TOG_W  = min1_clog2(TOGGLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             shift_i,
  output logic             half_stb_c,
  output logic             lead_stb_c,
  output logic             trail_stb_c,
  output logic [TOG_W-1:0] tog_cnt_o
);

  localparam int unsigned DIV_W = min1_clog2(HALF);

  logic [DIV_W-1:0] div_q, div_d;
  logic [TOG_W-1:0] tog_q, tog_d;

  assign half_stb_c  = (div_q == DIV_W'(HALF - 1));
  assign lead_stb_c  = shift_i && half_stb_c && !tog_q[0];
  assign trail_stb_c = shift_i && half_stb_c && tog_q[0];
  assign tog_cnt_o   = tog_q;

  // Clear wins so every state starts its count from zero.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    tog_d = tog_q;
    if (half_stb_c) div_d = '0;
    if (shift_i && half_stb_c) tog_d = tog_q + TOG_W'(1);
    if (clr_i) begin
      div_d = '0;
      tog_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      tog_q <= '0;
    end else begin
      div_q <= div_d;
      tog_q <= tog_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master: DATA_W-bit MSB-first words, CPOL/CPHA modes, NUM_CS selects.
module spi_master_param
  import spi_master_param_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NUM_CS  = 1,
  localparam int unsigned CS_W   = min1_clog2(NUM_CS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              polarity,
  input  logic              phase,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned HALF    = CLK_DIV / 2;
  localparam int unsigned TOGGLES = 2 * DATA_W;
  localparam int unsigned TOG_W   = min1_clog2(TOGGLES);
  localparam int unsigned BIT_W   = min1_clog2(DATA_W);

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [CS_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                spi_clk_q, spi_clk_d, mosi_q, mosi_d;

  logic                half_stb, lead_stb, trail_stb, last_stb;
  logic [TOG_W-1:0]    tog_cnt;
  logic                load, shifting, active, sample, drive;

  spi_master_param_clk_gen #(
    .HALF    (HALF),
    .TOGGLES (TOGGLES)
  ) u_clk_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_i       (state_d != state_q),
    .shift_i     (shifting),
    .half_stb_c  (half_stb),
    .lead_stb_c  (lead_stb),
    .trail_stb_c (trail_stb),
    .tog_cnt_o   (tog_cnt)
  );

  assign load     = (state_q == ST_IDLE) && start;
  assign shifting = (state_q == ST_SHIFT);
  assign last_stb = trail_stb && (tog_cnt == TOG_W'(TOGGLES - 1));
  assign active   = state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD};
  assign sample   = mode_q[MODE_CPHA] ? trail_stb : lead_stb;
  // CPHA=1 re-drives on leading edges except the first (MSB already out since SETUP).
  assign drive    = mode_q[MODE_CPHA] ? (lead_stb && (bit_q != BIT_W'(DATA_W - 1)))
                                      : (trail_stb && !last_stb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)    state_d = ST_SETUP;
      ST_SETUP: if (half_stb) state_d = ST_SHIFT;
      ST_SHIFT: if (last_stb) state_d = ST_HOLD;
      ST_HOLD:  if (half_stb) state_d = ST_END;
      ST_END:                 state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; outputs follow the next state so they are registered.
  always_comb begin
    mode_d    = mode_q;
    sel_d     = sel_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    bit_d     = bit_q;
    rx_data_d = rx_data_q;
    cs_n_d    = '1;
    if (state_q == ST_IDLE) mode_d[MODE_CPOL] = polarity;
    if (load) begin
      mode_d[MODE_CPHA] = phase;
      sel_d             = cs_sel;
      tx_sh_d           = tx_data;
      rx_sh_d           = '0;
      bit_d             = BIT_W'(DATA_W - 1);
    end else if (shifting) begin
      if (drive) tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
      if (sample) begin
        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
        if (bit_q != '0) bit_d = bit_q - BIT_W'(1);
      end
    end
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (active && (sel_d == CS_W'(i))) cs_n_d[i] = 1'b0;
    end
    busy_d    = active;
    done_d    = (state_d == ST_END);
    mosi_d    = active ? tx_sh_d[DATA_W-1] : 1'b1;
    if (state_d == ST_END) rx_data_d = rx_sh_q;
    if (shifting) spi_clk_d = (lead_stb || trail_stb) ? !spi_clk_q : spi_clk_q;
    else          spi_clk_d = mode_d[MODE_CPOL];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= '0;
      sel_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      bit_q     <= '0;
      rx_data_q <= '0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spi_clk_q <= 1'b0;
      mosi_q    <= 1'b1;
    end else begin
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      bit_q     <= bit_d;
      rx_data_q <= rx_data_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      spi_clk_q <= spi_clk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign spi_clk = spi_clk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: default 8-bit instance against an SPI slave model, plus a 16-bit/4-CS instance.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic       start0, pol0, pha0, busy0, done0, sclk0, mosi0, miso0;
  logic [0:0] sel0, csn0;
  logic [7:0] tx0, rx0;

  logic        start1, pol1, pha1, busy1, done1, sclk1, mosi1, miso1;
  logic [1:0]  sel1;
  logic [3:0]  csn1;
  logic [15:0] tx1, rx1;

  spi_master_param dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .polarity(pol0), .phase(pha0),
    .cs_sel(sel0), .tx_data(tx0), .rx_data(rx0), .busy(busy0), .done(done0),
    .spi_clk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(csn0)
  );

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .polarity(pol1), .phase(pha1),
    .cs_sel(sel1), .tx_data(tx1), .rx_data(rx1), .busy(busy1), .done(done1),
    .spi_clk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(csn1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // miso source for dut0: 0 loopback, 1 tied high, 2 slave model
  int         src = 0;
  logic       slv_miso = 1'b0;
  logic [7:0] slv_word = '0;
  logic       m_cpol = 1'b0, m_cpha = 1'b0;
  assign miso0 = (src == 0) ? mosi0 : (src == 1) ? 1'b1 : slv_miso;
  assign miso1 = mosi1;

  // Behavioural SPI slave: shifts slv_word out and captures mosi by the CPOL/CPHA rules.
  logic       p_clk = 1'b0, p_cs = 1'b1, p_mosi = 1'b1;
  int         k_lead = 0, k_trail = 0, m_bad = 0;
  logic [7:0] m_cap = '0;
  always @(negedge clk) begin
    logic lead_e, trail_e, drive_e;
    if (!reset_n) begin
      p_cs = 1'b1;
    end else begin
      if (csn0[0] == 1'b0 && p_cs == 1'b1) begin
        k_lead = 0; k_trail = 0; m_cap = '0; m_bad = 0;
        if (!m_cpha) slv_miso = slv_word[7];
      end else if (csn0[0] == 1'b0) begin
        lead_e  = (sclk0 != p_clk) && (sclk0 != m_cpol);
        trail_e = (sclk0 != p_clk) && (sclk0 == m_cpol);
        if (lead_e) begin
          k_lead++;
          if (m_cpha) begin
            if (k_lead <= 8) slv_miso = slv_word[8-k_lead];
          end else m_cap = {m_cap[6:0], mosi0};
        end
        if (trail_e) begin
          k_trail++;
          if (m_cpha) m_cap = {m_cap[6:0], mosi0};
          else if (k_trail < 8) slv_miso = slv_word[7-k_trail];
        end
        drive_e = m_cpha ? lead_e : trail_e;
        if (mosi0 != p_mosi && !drive_e) m_bad++;
      end
      p_clk = sclk0; p_cs = csn0[0]; p_mosi = mosi0;
    end
  end

  typedef struct {
    logic [1:0] mode;   // {cpol, cpha}
    logic [7:0] tx;
    logic       sel;
    int         src;
    logic [7:0] slv;
    logic [7:0] exp_rx;
    bit         b2b;
    bit         poke;
  } vec_t;

  task automatic run0(input vec_t v);
    int c;
    int dones;
    bit got;
    m_cpol = v.mode[1]; m_cpha = v.mode[0];
    pol0 = v.mode[1]; pha0 = v.mode[0]; tx0 = v.tx; sel0 = v.sel;
    src = v.src; slv_word = v.slv;
    if (!v.b2b) begin
      repeat (2) @(negedge clk);
      chk("idle_sclk", 32'(sclk0), 32'(v.mode[1]));
    end
    start0 = 1'b1;
    @(posedge clk);
    c = 0; got = 0;
    while (c < 100 && !got) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        start0 = 1'b0;
        chk("busy_c1", 32'(busy0), 1);
        chk("csn_c1", 32'(csn0), (v.sel == 1'b0) ? 0 : 1);
      end
      if (c == 3) begin
        pol0 = 1'($urandom); pha0 = 1'($urandom); tx0 = 8'($urandom); sel0 = 1'($urandom);
      end
      if (v.poke && c == 10) start0 = 1'b1;
      if (v.poke && c == 11) start0 = 1'b0;
      if (done0) got = 1;
    end
    chk("done_cycle", c, 37);
    chk("rx_data", 32'(rx0), 32'(v.exp_rx));
    chk("busy_at_done", 32'(busy0), 0);
    chk("csn_at_done", 32'(csn0), 1);
    chk("sclk_after", 32'(sclk0), 32'(v.mode[1]));
    @(negedge clk);
    chk("done_width", 32'(done0), 0);
    chk("csn_gap", 32'(csn0), 1);
    if (v.sel == 1'b0) begin
      chk("slave_cap", 32'(m_cap), 32'(v.tx));
      chk("lead_edges", k_lead, 8);
      chk("mosi_edge", m_bad, 0);
    end
    if (v.poke) begin
      dones = 0;
      repeat (45) begin
        @(negedge clk);
        if (done0) dones++;
      end
      chk("poke_extra_done", dones, 0);
    end
  endtask

  task automatic run1(input logic [1:0] mode, input logic [1:0] sel, input logic [15:0] tx,
                      input logic [3:0] exp_csn);
    int c;
    bit got;
    pol1 = mode[1]; pha1 = mode[0]; sel1 = sel; tx1 = tx;
    repeat (2) @(negedge clk);
    chk("w16_idle_sclk", 32'(sclk1), 32'(mode[1]));
    start1 = 1'b1;
    @(posedge clk);
    c = 0; got = 0;
    while (c < 100 && !got) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        start1 = 1'b0;
        chk("w16_csn", 32'(csn1), 32'(exp_csn));
      end
      if (done1) got = 1;
    end
    chk("w16_done_cycle", c, 35);
    chk("w16_rx", 32'(rx1), 32'(tx));
    chk("w16_csn_done", 32'(csn1), 32'hF);
  endtask

  vec_t tbl[6];

  initial begin
    int c;
    int dones;
    vec_t v;
    tbl[0] = '{mode: 2'd0, tx: 8'hA5, sel: 1'b0, src: 0, slv: 8'h00, exp_rx: 8'hA5, b2b: 0, poke: 1};
    tbl[1] = '{mode: 2'd3, tx: 8'h3C, sel: 1'b0, src: 1, slv: 8'h00, exp_rx: 8'hFF, b2b: 0, poke: 0};
    tbl[2] = '{mode: 2'd1, tx: 8'h96, sel: 1'b0, src: 2, slv: 8'h5A, exp_rx: 8'h5A, b2b: 0, poke: 0};
    tbl[3] = '{mode: 2'd2, tx: 8'h0F, sel: 1'b0, src: 2, slv: 8'h5A, exp_rx: 8'h5A, b2b: 1, poke: 0};
    tbl[4] = '{mode: 2'd0, tx: 8'h81, sel: 1'b1, src: 0, slv: 8'h00, exp_rx: 8'h81, b2b: 0, poke: 0};
    tbl[5] = '{mode: 2'd0, tx: 8'h5A, sel: 1'b0, src: 0, slv: 8'h00, exp_rx: 8'h5A, b2b: 0, poke: 0};

    reset_n = 1'b0;
    start0 = 0; pol0 = 0; pha0 = 0; sel0 = '0; tx0 = '0;
    start1 = 0; pol1 = 0; pha1 = 0; sel1 = '0; tx1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_csn0", 32'(csn0), 1);
    chk("rst_sclk0", 32'(sclk0), 0);
    chk("rst_mosi0", 32'(mosi0), 1);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_done0", 32'(done0), 0);
    chk("rst_rx0", 32'(rx0), 0);
    chk("rst_csn1", 32'(csn1), 32'hF);
    reset_n = 1'b1;

    run1(2'd0, 2'd2, 16'hBEEF, 4'b1011);
    run1(2'd3, 2'd0, 16'h1234, 4'b1110);

    for (int i = 0; i < 6; i++) run0(tbl[i]);

    // Random modes and slave words; an ideal slave's word must come back unchanged.
    for (int i = 0; i < 10; i++) begin
      v.mode = 2'($urandom); v.tx = 8'($urandom); v.sel = 1'b0; v.src = 2;
      v.slv = 8'($urandom); v.exp_rx = v.slv; v.b2b = 1'($urandom); v.poke = 0;
      run0(v);
    end
    run0(tbl[5]);

    // Abort mid-transfer with reset.
    pol0 = 1'b1; pha0 = 1'b0; tx0 = 8'hC3; sel0 = 1'b0; src = 0;
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    c = 0;
    while (c < 15) begin
      @(negedge clk);
      c++;
      if (c == 1) start0 = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk("abort_csn", 32'(csn0), 1);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_rx", 32'(rx0), 0);
    chk("abort_done", 32'(done0), 0);
    chk("abort_sclk", 32'(sclk0), 0);
    chk("abort_mosi", 32'(mosi0), 1);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (done0) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_idle_busy", 32'(busy0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
